alu_mdu: RTL and testbench



---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_mdu_iter.sv | 103 ++++++++++
 rtl/alu_mdu.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_alu_mdu.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the EX-stage ALU / multiply-divide unit:
//   alu_op_e          - 4-bit operation codes driven on alu_ctrl
//   mdu_state_e       - sequencing states of the alu_mdu controller
//   ALU_WIDTH_DEFAULT - default datapath width
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_WIDTH_DEFAULT = 32;

    typedef enum logic [3:0] {
        OP_AND   = 4'b0000,
        OP_OR    = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_ADDU  = 4'b0011,
        OP_SUBU  = 4'b0100,
        OP_ILL   = 4'b0101,
        OP_SUB   = 4'b0110,
        OP_SLT   = 4'b0111,
        OP_SLTU  = 4'b1000,
        OP_MULT  = 4'b1001,
        OP_MULTU = 4'b1010,
        OP_DIV   = 4'b1011,
        OP_NOR   = 4'b1100,
        OP_DIVU  = 4'b1101,
        OP_MFHI  = 4'b1110,
        OP_MFLO  = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIN  = 2'd3
    } mdu_state_e;

endpackage

// File: rtl/alu_mdu_iter.sv
// -----------------------------------------------------------------------------
// alu_mdu_iter
// Iterative unsigned datapath of the MDU: shift-add multiplier and (when
// ALU_MDU_DIV_EN is defined) restoring divider, one bit per clock, WIDTH steps.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start_mul    load magnitudes and start a WIDTH-step multiply
//   start_div    load magnitudes and start a WIDTH-step divide (ALU_MDU_DIV_EN)
//   mag_a        multiplicand / dividend magnitude
//   mag_b        multiplier / divisor magnitude
//   done_iter    high during the cycle whose clock edge performs the last step
//   partial      value the accumulator takes at the next edge:
//                multiply {hi,lo} product, divide {remainder,quotient}
// -----------------------------------------------------------------------------
module alu_mdu_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_mul,
`ifdef ALU_MDU_DIV_EN
    input  logic                 start_div,
`endif
    input  logic [WIDTH-1:0]     mag_a,
    input  logic [WIDTH-1:0]     mag_b,
    output logic                 done_iter,
    output logic [2*WIDTH-1:0]   partial
);

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] w_next;
    logic [WIDTH-1:0]   r_opb;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_run;
    logic               w_load;
    logic [WIDTH:0]     w_add;
`ifdef ALU_MDU_DIV_EN
    logic               r_div;
    logic [WIDTH:0]     w_shl;
    logic [WIDTH:0]     w_sub;
`endif

`ifdef ALU_MDU_DIV_EN
    assign w_load = start_mul || start_div;
`else
    assign w_load = start_mul;
`endif

    assign done_iter = r_run && (r_cnt == CNT_W'(WIDTH - 1));
    assign partial   = w_next;

    // Multiply: upper half accumulates, carry kept in bit WIDTH of w_add and
    // shifted back in. Divide: shift remainder left, subtract divisor, keep
    // the difference only when it did not borrow.
    always_comb begin
        w_add  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
        w_next = {w_add, r_acc[WIDTH-1:1]};
`ifdef ALU_MDU_DIV_EN
        w_shl = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_sub = w_shl - {1'b0, r_opb};
        if (r_div) begin
            if (!w_sub[WIDTH]) begin
                w_next = {w_sub[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
            end else begin
                w_next = {w_shl[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_opb <= '0;
            r_cnt <= '0;
            r_run <= 1'b0;
`ifdef ALU_MDU_DIV_EN
            r_div <= 1'b0;
`endif
        end else if (w_load) begin
            r_acc <= {{WIDTH{1'b0}}, mag_b};
            r_opb <= mag_a;
            r_cnt <= '0;
            r_run <= 1'b1;
`ifdef ALU_MDU_DIV_EN
            r_div <= start_div;
            if (start_div) begin
                r_acc <= {{WIDTH{1'b0}}, mag_a};
                r_opb <= mag_b;
            end
`endif
        end else if (r_run) begin
            r_acc <= w_next;
            r_cnt <= r_cnt + CNT_W'(1);
            if (done_iter) begin
                r_run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// -----------------------------------------------------------------------------
// alu_mdu
// Registered EX-stage ALU with iterative multiply/divide and HI/LO registers.
// Single-cycle ops complete one clock after an accepted start; MULT/MULTU and
// DIV/DIVU take WIDTH+1 clocks. Divide support is built only when the macro
// ALU_MDU_DIV_EN is defined; otherwise DIV/DIVU finish in one cycle with
// alu_result=0 and HI/LO untouched.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   start                          request, accepted only in IDLE
//   alu_ctrl                       operation code (alu_pkg::alu_op_e)
//   op_1, op_2                     operands
//   alu_result                     registered result, valid with done
//   done                           one-cycle completion pulse
//   busy                           MDU iterating, start ignored
//   arith_ovrflw_exceptn_detected  signed overflow of ADD/SUB
//   div_by_zero                    DIV/DIVU with op_2 = 0
//   hi, lo                         architectural HI/LO registers
// -----------------------------------------------------------------------------
module alu_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH_DEFAULT,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_1,
    input  logic [WIDTH-1:0] op_2,
    output logic [WIDTH-1:0] alu_result,
    output logic             done,
    output logic             busy,
    output logic             arith_ovrflw_exceptn_detected,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    function automatic logic [WIDTH-1:0] f_neg(input logic neg, input logic [WIDTH-1:0] v);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] f_neg2(input logic neg, input logic [2*WIDTH-1:0] v);
        return neg ? -v : v;
    endfunction

    mdu_state_e         r_state, w_next_state;
    alu_op_e            w_op;
    logic               w_is_mul, w_signed_op, w_neg_a, w_neg_b;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_sum, w_diff, w_sc_result;
    logic [WIDTH-1:0]   w_new_hi, w_new_lo;
    logic               w_sc_ovf, w_start_mul, w_mdu_load, w_sc_load, w_fin_load;
    logic               w_done_iter;
    logic [2*WIDTH-1:0] w_partial, w_prod;
    logic               r_neg_q, r_done, r_ovf, r_dzf;
    logic [WIDTH-1:0]   r_result, r_hi, r_lo;
`ifdef ALU_MDU_DIV_EN
    logic               w_is_div, w_div_zero, w_start_div;
    logic               r_is_div, r_dz, r_neg_r;
    logic [WIDTH-1:0]   r_dz_hi, w_quo, w_rem;
`endif

    assign w_op = alu_op_e'(alu_ctrl);

    always_comb begin
        w_is_mul    = (w_op == OP_MULT) || (w_op == OP_MULTU);
        w_signed_op = (w_op == OP_MULT);
`ifdef ALU_MDU_DIV_EN
        w_is_div    = (w_op == OP_DIV) || (w_op == OP_DIVU);
        w_div_zero  = w_is_div && (op_2 == '0);
        w_signed_op = w_signed_op || (w_op == OP_DIV);
`endif
    end

    // Signed MDU ops iterate on magnitudes; signs are reapplied at FIN.
    assign w_neg_a = w_signed_op && op_1[WIDTH-1];
    assign w_neg_b = w_signed_op && op_2[WIDTH-1];
    assign w_mag_a = f_neg(w_neg_a, op_1);
    assign w_mag_b = f_neg(w_neg_b, op_2);

    // Single-cycle results
    assign w_sum  = op_1 + op_2;
    assign w_diff = op_1 - op_2;

    always_comb begin
        w_sc_result = '0;
        w_sc_ovf    = 1'b0;
        case (w_op)
            OP_AND:  w_sc_result = op_1 & op_2;
            OP_OR:   w_sc_result = op_1 | op_2;
            OP_NOR:  w_sc_result = ~(op_1 | op_2);
            OP_ADDU: w_sc_result = w_sum;
            OP_SUBU: w_sc_result = w_diff;
            OP_ADD: begin
                w_sc_result = w_sum;
                w_sc_ovf    = (op_1[WIDTH-1] == op_2[WIDTH-1]) && (w_sum[WIDTH-1] != op_1[WIDTH-1]);
            end
            OP_SUB: begin
                w_sc_result = w_diff;
                w_sc_ovf    = (op_1[WIDTH-1] != op_2[WIDTH-1]) && (w_diff[WIDTH-1] != op_1[WIDTH-1]);
            end
            OP_SLT:  w_sc_result = {{(WIDTH-1){1'b0}}, ($signed(op_1) < $signed(op_2))};
            OP_SLTU: w_sc_result = {{(WIDTH-1){1'b0}}, (op_1 < op_2)};
            OP_MFHI: w_sc_result = r_hi;
            OP_MFLO: w_sc_result = r_lo;
            default: w_sc_result = '0;
        endcase
    end

    alu_mdu_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_mul (w_start_mul),
`ifdef ALU_MDU_DIV_EN
        .start_div (w_start_div),
`endif
        .mag_a     (w_mag_a),
        .mag_b     (w_mag_b),
        .done_iter (w_done_iter),
        .partial   (w_partial)
    );

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM: next state
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (w_is_mul) begin
                        w_next_state = ST_MUL;
                    end
`ifdef ALU_MDU_DIV_EN
                    // Divide-by-zero also spends one cycle in DIV, without iterating.
                    else if (w_is_div) begin
                        w_next_state = ST_DIV;
                    end
`endif
                end
            end
            ST_MUL: if (w_done_iter) w_next_state = ST_FIN;
`ifdef ALU_MDU_DIV_EN
            ST_DIV: if (r_dz || w_done_iter) w_next_state = ST_FIN;
`endif
            ST_FIN:  w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // FSM: outputs / datapath strobes
    always_comb begin
        busy        = 1'b0;
        w_start_mul = 1'b0;
        w_mdu_load  = 1'b0;
        w_sc_load   = 1'b0;
        w_fin_load  = 1'b0;
`ifdef ALU_MDU_DIV_EN
        w_start_div = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (w_is_mul) begin
                        w_start_mul = 1'b1;
                        w_mdu_load  = 1'b1;
                    end
`ifdef ALU_MDU_DIV_EN
                    else if (w_is_div) begin
                        w_start_div = !w_div_zero;
                        w_mdu_load  = 1'b1;
                    end
`endif
                    else begin
                        w_sc_load = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                busy       = 1'b1;
                w_fin_load = w_done_iter;
            end
`ifdef ALU_MDU_DIV_EN
            ST_DIV: begin
                busy       = 1'b1;
                w_fin_load = r_dz || w_done_iter;
            end
`endif
            default: ;
        endcase
    end

    // Sign correction of the finished iteration (FIN values)
    always_comb begin
        w_prod   = f_neg2(r_neg_q, w_partial);
        w_new_hi = w_prod[2*WIDTH-1:WIDTH];
        w_new_lo = w_prod[WIDTH-1:0];
`ifdef ALU_MDU_DIV_EN
        // Truncating division: remainder follows the dividend's sign.
        w_quo = f_neg(r_neg_q, w_partial[WIDTH-1:0]);
        w_rem = f_neg(r_neg_r, w_partial[2*WIDTH-1:WIDTH]);
        if (r_is_div) begin
            if (r_dz) begin
                w_new_hi = r_dz_hi;
                w_new_lo = '1;
            end else begin
                w_new_hi = w_rem;
                w_new_lo = w_quo;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_neg_q  <= 1'b0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
            r_dzf    <= 1'b0;
            r_result <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
`ifdef ALU_MDU_DIV_EN
            r_is_div <= 1'b0;
            r_dz     <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz_hi  <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            if (w_mdu_load) begin
                r_neg_q  <= w_neg_a ^ w_neg_b;
`ifdef ALU_MDU_DIV_EN
                r_is_div <= w_is_div;
                r_dz     <= w_div_zero;
                r_neg_r  <= w_neg_a;
                r_dz_hi  <= op_1;
`endif
            end
            if (w_sc_load) begin
                r_result <= w_sc_result;
                r_ovf    <= w_sc_ovf;
                r_dzf    <= 1'b0;
                r_done   <= 1'b1;
            end
            if (w_fin_load) begin
                r_hi     <= w_new_hi;
                r_lo     <= w_new_lo;
                r_result <= w_new_lo;
                r_ovf    <= 1'b0;
`ifdef ALU_MDU_DIV_EN
                r_dzf    <= r_is_div && r_dz;
`else
                r_dzf    <= 1'b0;
`endif
                r_done   <= 1'b1;
            end
        end
    end

    assign alu_result                    = r_result;
    assign done                          = r_done;
    assign arith_ovrflw_exceptn_detected = r_ovf;
    assign div_by_zero                   = r_dzf;
    assign hi                            = r_hi;
    assign lo                            = r_lo;

endmodule

// File: tb/tb_alu_mdu.sv
// -----------------------------------------------------------------------------
// tb_alu_mdu
// Directed and randomized bench for alu_mdu (WIDTH=32). Expected values come
// from a plain-arithmetic reference model (64-bit products, native / and %).
// Divide expectations follow the ALU_MDU_DIV_EN build option.
// -----------------------------------------------------------------------------
module tb_alu_mdu;

    localparam int W = 32;
    localparam longint MAXS = 64'sh0000_0000_7FFF_FFFF;
    localparam longint MINS = -64'sh0000_0000_8000_0000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [3:0]    alu_ctrl;
    logic [W-1:0]  op_1, op_2;
    logic [W-1:0]  alu_result, hi, lo;
    logic          done, busy, ovf, dz;

    int            n_vec  = 0;
    int            n_miss = 0;
    logic [W-1:0]  m_hi = '0;
    logic [W-1:0]  m_lo = '0;

    alu_mdu #(.WIDTH(W)) dut (
        .clk                           (clk),
        .rst_n                         (rst_n),
        .start                         (start),
        .alu_ctrl                      (alu_ctrl),
        .op_1                          (op_1),
        .op_2                          (op_2),
        .alu_result                    (alu_result),
        .done                          (done),
        .busy                          (busy),
        .arith_ovrflw_exceptn_detected (ovf),
        .div_by_zero                   (dz),
        .hi                            (hi),
        .lo                            (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: updates m_hi/m_lo, returns result, flags and latency.
    task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic ov, output logic dzf, output int lat);
        longint      sa, sb, s;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        r = '0; ov = 1'b0; dzf = 1'b0; lat = 1;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b1100: r = ~(a | b);
            4'b0011: r = a + b;
            4'b0100: r = a - b;
            4'b0010: begin s = sa + sb; r = a + b; ov = (s > MAXS) || (s < MINS); end
            4'b0110: begin s = sa - sb; r = a - b; ov = (s > MAXS) || (s < MINS); end
            4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
            4'b1000: r = (ua < ub) ? 32'd1 : 32'd0;
            4'b1110: r = m_hi;
            4'b1111: r = m_lo;
            4'b1001: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; r = m_lo; lat = W + 1; end
            4'b1010: begin p = ua * ub; m_hi = p[63:32]; m_lo = p[31:0]; r = m_lo; lat = W + 1; end
`ifdef ALU_MDU_DIV_EN
            4'b1011, 4'b1101: begin
                if (b == '0) begin
                    m_lo = '1; m_hi = a; dzf = 1'b1; lat = 2;
                end else if (op == 4'b1011) begin
                    s = sa / sb; p = sa % sb;
                    m_lo = s[31:0]; m_hi = p[31:0]; lat = W + 1;
                end else begin
                    p = ua / ub; m_lo = p[31:0];
                    p = ua % ub; m_hi = p[31:0]; lat = W + 1;
                end
                r = m_lo;
            end
`endif
            default: r = '0;
        endcase
    endtask

    task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int poke_cyc, input logic [3:0] poke_op, input logic fin_poke);
        logic [W-1:0] e_r, old_hi, old_lo;
        logic         e_ov, e_dz;
        int           e_lat, cyc;
        string        t;
        old_hi = m_hi;
        old_lo = m_lo;
        model(op, a, b, e_r, e_ov, e_dz, e_lat);
        t = $sformatf("op%h %h,%h", op, a, b);
        @(negedge clk);
        start = 1'b1; alu_ctrl = op; op_1 = a; op_2 = b;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 60) begin
            chk({t, $sformatf(" wait c%0d busy/hi/lo", cyc)}, {busy, hi, lo}, {1'b1, old_hi, old_lo});
            start = (cyc == poke_cyc);
            if (start) alu_ctrl = poke_op;
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        chk({t, " latency"}, cyc, e_lat);
        chk({t, " result"}, alu_result, e_r);
        chk({t, " ovf/dz/busy"}, {ovf, dz, busy}, {e_ov, e_dz, 1'b0});
        chk({t, " hi"}, hi, m_hi);
        chk({t, " lo"}, lo, m_lo);
        if (fin_poke && e_lat > 1) begin
            start = 1'b1; alu_ctrl = 4'b0010;
        end
        @(posedge clk); #1;
        start = 1'b0;
        chk({t, " done pulse"}, done, 1'b0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 9))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n_done;
        rst_n = 1'b0; start = 1'b0; alu_ctrl = '0; op_1 = '0; op_2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset outputs", {alu_result, done, busy, ovf, dz, hi, lo},
            {32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0});
        @(negedge clk); rst_n = 1'b1;

        // Single-cycle ops
        do_op(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 0, 4'h0, 1'b0);
        do_op(4'b0011, 32'h7FFF_FFFF, 32'h0000_0001, 0, 4'h0, 1'b0);
        do_op(4'b0110, 32'h8000_0000, 32'h0000_0001, 0, 4'h0, 1'b0);
        do_op(4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 0, 4'h0, 1'b0);
        do_op(4'b1000, 32'hFFFF_FFFF, 32'h0000_0001, 0, 4'h0, 1'b0);
        do_op(4'b1100, 32'h0000_0000, 32'h0000_0000, 0, 4'h0, 1'b0);
        do_op(4'b0101, 32'h1234_5678, 32'h9ABC_DEF0, 0, 4'h0, 1'b0);

        // MULT with an ignored ADD at cycle 10 and an ignored start during FIN
        do_op(4'b1001, 32'hFFFF_FFFD, 32'h0000_0005, 10, 4'b0010, 1'b1);

        // Divides and moves from HI/LO
        do_op(4'b1101, 32'h0000_0007, 32'h0000_0002, 0, 4'h0, 1'b0);
        do_op(4'b1011, 32'hFFFF_FFF9, 32'h0000_0002, 0, 4'h0, 1'b0);
        do_op(4'b1111, 32'h0, 32'h0, 0, 4'h0, 1'b0);
        do_op(4'b1011, 32'h1234_5678, 32'h0000_0000, 0, 4'h0, 1'b0);
        do_op(4'b1110, 32'h0, 32'h0, 0, 4'h0, 1'b0);
        do_op(4'b1011, 32'h8000_0000, 32'hFFFF_FFFF, 0, 4'h0, 1'b0);

        // Reset in the middle of MULTU
        @(negedge clk);
        start = 1'b1; alu_ctrl = 4'b1010; op_1 = 32'hFFFF_FFFF; op_2 = 32'h0000_0003;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("busy before abort", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort outputs", {busy, hi, lo, done, alu_result}, {1'b0, 32'h0, 32'h0, 1'b0, 32'h0});
        m_hi = '0; m_lo = '0;
        @(negedge clk); rst_n = 1'b1;
        n_done = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) n_done++;
        end
        chk("no done after abort", n_done, 0);
        do_op(4'b1010, 32'hFFFF_FFFF, 32'h0000_0002, 0, 4'h0, 1'b0);
        do_op(4'b1110, 32'h0, 32'h0, 0, 4'h0, 1'b0);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            logic [3:0] rop;
            rop = 4'($urandom_range(0, 15));
            do_op(rop, pick(), pick(), $urandom_range(0, W), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
